xnor_cmp_sched: RTL and testbench
=================================

XNOR_CMP_SCHED -- requirements
Module: xnor_cmp_sched

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req_i  input  2  per-requester compare request, level, held until ack.
REQ-006 Port: a0_i, b0_i  input  WIDTH  requester 0 operands, stable while req_i[0] high.
REQ-007 Port: a1_i, b1_i  input  WIDTH  requester 1 operands, stable while req_i[1] high.
REQ-008 Port: ack_o  output  2  one-cycle registered acceptance pulse per requester.
REQ-009 Port: busy_o  output  1  high while a comparison is in progress (SHIFT or DONE).
REQ-010 Port: done_o  output  1  one-cycle result-valid pulse.
REQ-011 Port: match_o  output  1  1 = operands equal; valid only while done_o high.
REQ-012 Port: gnt_id_o  output  1  requester index of the current/last result; valid while busy_o high.

Function
REQ-013 The block SHALL share one 1-bit XNOR equality stage between two requesters, comparing operands bit-serially, LSB first.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; transitions: IDLE->SHIFT on capture, SHIFT->DONE after WIDTH shift edges, DONE->IDLE unconditionally after one cycle.
REQ-015 Capture: on a rising edge in IDLE with any req_i bit high, the block SHALL latch the granted operands into shift registers, clear the bit counter, set the match accumulator to 1, record gnt_id_o.
REQ-016 ack_o[k] SHALL be high for exactly the one cycle following the capture edge of requester k; ack_o SHALL never have both bits set.
REQ-017 Arbitration: single request is granted directly; if both are high, grant goes to the requester not granted last (round-robin); the last-grant pointer updates at capture.
REQ-018 Each SHIFT edge: accumulator <= accumulator AND XNOR(sa[0], sb[0]); both shift registers shift right one bit; counter increments.
REQ-019 Counter SHALL be ceil(log2(WIDTH+1)) bits; exit to DONE on the edge where it reaches WIDTH-1 before increment (exactly WIDTH shift edges, no wrap).
REQ-020 done_o SHALL be high for exactly one cycle, beginning WIDTH+1 rising edges after the capture edge; match_o = final accumulator during that cycle, 0 otherwise.
REQ-021 Requests SHALL be sampled only in IDLE; requests arriving in SHIFT/DONE wait; minimum spacing between capture edges is WIDTH+2 cycles.
REQ-022 A request deasserted before capture SHALL be ignored with no ack; operand changes after capture SHALL NOT affect the result.
REQ-023 No early termination: a mismatch in any bit still runs all WIDTH shifts.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, ack_o=0, busy_o=0, done_o=0, match_o=0, gnt_id_o=0, counter=0, accumulator=0, last-grant pointer=1 (requester 0 wins the first tie).
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the comparison with no done_o pulse; the aborted requester, if still requesting, is re-arbitrated after reset release.
REQ-026 First capture SHALL be possible on the first rising edge with rst_n high.

Verification (WIDTH=8)
REQ-027 req_i=01, a0=b0=8'hA5 -> ack_o=01 one cycle after capture, done_o 9 edges after capture, match_o=1, gnt_id_o=0.
REQ-028 req_i=10, a1=8'h80, b1=8'h00 (MSB-only difference) -> done_o after full 8 shifts, match_o=0, gnt_id_o=1.
REQ-029 req_i=11 held with equal operands on both -> grants alternate 0,1,0,1; captures spaced exactly 10 cycles apart.
REQ-030 req0 captured, a0 changed to differ during SHIFT -> match_o=1 (original operands used).
REQ-031 rst_n pulsed low at shift edge 4 -> all outputs 0 immediately, no done_o; after release req_i=01 held -> fresh capture, correct result.
REQ-032 a0=8'hFF, b0=8'hFE (LSB-only difference) -> match_o=0, no early done_o.

Source files
------------

// File: rtl/xnor_cmp_sched_if.sv
// Request/result bundle for the shared bit-serial equality comparator.
// The master side is the requester pair; the slave side is the scheduler.
interface xnor_cmp_sched_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       req_i;
   logic [WIDTH-1:0] a0_i;
   logic [WIDTH-1:0] b0_i;
   logic [WIDTH-1:0] a1_i;
   logic [WIDTH-1:0] b1_i;
   logic [1:0]       ack_o;
   logic             busy_o;
   logic             done_o;
   logic             match_o;
   logic             gnt_id_o;

   modport master (
      output req_i, a0_i, b0_i, a1_i, b1_i,
      input  ack_o, busy_o, done_o, match_o, gnt_id_o
   );

   modport slave (
      input  req_i, a0_i, b0_i, a1_i, b1_i,
      output ack_o, busy_o, done_o, match_o, gnt_id_o
   );
endinterface

// File: rtl/xnor_cmp_sched.sv
// Two requesters share one 1-bit XNOR stage; operands are compared LSB first
// over WIDTH shift cycles, with round-robin arbitration on ties.
module xnor_cmp_sched #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   xnor_cmp_sched_if.slave   bus
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CW-1:0]    cnt;
   logic             acc;
   logic             last_gnt;

   logic             any_req;
   logic             gnt_sel;
   logic             bit_eq;

   // On a tie the requester that did not win last time gets the slot.
   always_comb begin
      any_req = |bus.req_i;
      gnt_sel = (bus.req_i[0] & bus.req_i[1]) ? ~last_gnt : bus.req_i[1];
      bit_eq  = ~(sa[0] ^ sb[0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sa           <= '0;
         sb           <= '0;
         cnt          <= '0;
         acc          <= 1'b0;
         last_gnt     <= 1'b1;
         bus.ack_o    <= 2'b00;
         bus.busy_o   <= 1'b0;
         bus.done_o   <= 1'b0;
         bus.match_o  <= 1'b0;
         bus.gnt_id_o <= 1'b0;
      end else begin
         bus.ack_o   <= 2'b00;
         bus.done_o  <= 1'b0;
         bus.match_o <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  sa           <= gnt_sel ? bus.a1_i : bus.a0_i;
                  sb           <= gnt_sel ? bus.b1_i : bus.b0_i;
                  cnt          <= '0;
                  acc          <= 1'b1;
                  last_gnt     <= gnt_sel;
                  bus.gnt_id_o <= gnt_sel;
                  bus.ack_o    <= gnt_sel ? 2'b10 : 2'b01;
                  bus.busy_o   <= 1'b1;
                  state        <= SHIFT;
               end
            end
            SHIFT: begin
               // Always runs all WIDTH bits; a mismatch only clears acc.
               acc <= acc & bit_eq;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= DONE;
            end
            DONE: begin
               bus.busy_o  <= 1'b0;
               bus.done_o  <= 1'b1;
               bus.match_o <= acc;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xnor_cmp_sched.sv
// Directed bench for xnor_cmp_sched at WIDTH=8 with hand-computed results.
module tb_xnor_cmp_sched;

   logic clk;
   logic rst_n;
   int   n_tot;
   int   n_bad;
   int   cyc;
   int   cap_cyc;
   int   prev_cap;

   xnor_cmp_sched_if #(.WIDTH(8)) bus ();

   xnor_cmp_sched #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Capture edge, then wait for done_o; inputs must already be driven.
   task automatic do_cmp(input string tag, input bit hold, input bit pulse1,
                         input bit chg, input logic egnt, input logic ematch);
      int n;
      tick();
      cap_cyc = cyc;
      chk({tag, "_ack"},  {30'd0, bus.ack_o}, egnt ? 32'd2 : 32'd1);
      chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd1);
      chk({tag, "_gnt0"}, {31'd0, bus.gnt_id_o}, {31'd0, egnt});
      chk({tag, "_dn0"},  {31'd0, bus.done_o}, 32'd0);
      if (!hold) bus.req_i = 2'b00;
      if (chg) bus.a0_i = ~bus.a0_i;
      n = 0;
      while (!bus.done_o && n < 20) begin
         tick();
         n++;
         if (pulse1 && n == 2) bus.req_i[1] = 1'b1;
         if (pulse1 && n == 4) bus.req_i[1] = 1'b0;
      end
      chk({tag, "_lat"},   n, 32'd9);
      chk({tag, "_match"}, {31'd0, bus.match_o}, {31'd0, ematch});
      chk({tag, "_gnt"},   {31'd0, bus.gnt_id_o}, {31'd0, egnt});
      chk({tag, "_busy1"}, {31'd0, bus.busy_o}, 32'd0);
   endtask

   initial begin
      n_tot = 0;
      n_bad = 0;
      prev_cap = 0;
      rst_n = 1'b0;
      bus.req_i = 2'b00;
      bus.a0_i = '0; bus.b0_i = '0; bus.a1_i = '0; bus.b1_i = '0;
      #3;
      chk("rst_ack",   {30'd0, bus.ack_o}, 32'd0);
      chk("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
      chk("rst_done",  {31'd0, bus.done_o}, 32'd0);
      chk("rst_match", {31'd0, bus.match_o}, 32'd0);
      chk("rst_gnt",   {31'd0, bus.gnt_id_o}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Equal operands, requester 0, captured on first edge out of reset
      bus.a0_i = 8'hA5; bus.b0_i = 8'hA5; bus.req_i = 2'b01;
      do_cmp("eq0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("eq0_dnoff", {31'd0, bus.done_o}, 32'd0);
      chk("eq0_moff",  {31'd0, bus.match_o}, 32'd0);

      // MSB-only difference, requester 1
      bus.a1_i = 8'h80; bus.b1_i = 8'h00; bus.req_i = 2'b10;
      do_cmp("msb1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // Both held: last grant was 1, so 0,1,0,1 at 10-cycle spacing
      bus.a0_i = 8'h5A; bus.b0_i = 8'h5A; bus.a1_i = 8'hC3; bus.b1_i = 8'hC3;
      bus.req_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         do_cmp("rr", 1'b1, 1'b0, 1'b0, k[0], 1'b1);
         if (k > 0) chk("rr_space", cap_cyc - prev_cap, 32'd10);
         prev_cap = cap_cyc;
      end
      bus.req_i = 2'b00;
      tick();
      chk("rr_idle_ack", {30'd0, bus.ack_o}, 32'd0);

      // Operand change after capture must not matter
      bus.a0_i = 8'h3C; bus.b0_i = 8'h3C; bus.req_i = 2'b01;
      do_cmp("chg", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();

      // Reset at shift edge 4 of a requester-1 comparison
      bus.a1_i = 8'h11; bus.b1_i = 8'h11; bus.req_i = 2'b10;
      tick();
      chk("abt_ack", {30'd0, bus.ack_o}, 32'd2);
      bus.req_i = 2'b00;
      repeat (4) tick();
      chk("abt_busy_pre", {31'd0, bus.busy_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abt_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("abt_gnt",  {31'd0, bus.gnt_id_o}, 32'd0);
      chk("abt_ack0", {30'd0, bus.ack_o}, 32'd0);
      chk("abt_done", {31'd0, bus.done_o}, 32'd0);
      chk("abt_match", {31'd0, bus.match_o}, 32'd0);
      repeat (12) begin
         tick();
         chk("abt_nodone", {31'd0, bus.done_o}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.a0_i = 8'h77; bus.b0_i = 8'h77; bus.req_i = 2'b01;
      do_cmp("post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // LSB-only difference; a short req1 pulse during SHIFT is dropped
      bus.a0_i = 8'hFF; bus.b0_i = 8'hFE; bus.req_i = 2'b01;
      do_cmp("lsb", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) begin
         tick();
         chk("lsb_noack",  {30'd0, bus.ack_o}, 32'd0);
         chk("lsb_nobusy", {31'd0, bus.busy_o}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
